decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Second stage of the 5-stage RV32I pipeline; the consumer of the fetch stage's outputs InstrD/PCD/PCPlus4D.
- Decodes the instruction and reads the register file, which has a writeback write port.
- Sign-extends the immediate and registers everything into the D/E pipeline register.
- Execute later resolves branches from these outputs and returns PCSrcE/PCTargetE to fetch.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural registers; x0 hardwired to zero.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- InstrD  in  32  instruction from fetch
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- FlushE  in  1  synchronous bubble insert into E register
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback destination
- ResultW  in  32  writeback data
- RegWriteE  out  1
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- MemWriteE  out  1
- JumpE  out  1
- BranchE  out  1
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ALUSrcE  out  1  1 = immediate
- RD1E, RD2E  out  32  register operands
- Rs1E, Rs2E, RdE  out  5  register indices
- ImmExtE  out  32  extended immediate
- PCE, PCPlus4E  out  32

Behaviour:
- Reset (async, high): all E outputs 0; all 31 writable registers cleared to 0. Reset mid-operation drops the in-flight instruction.
- Latency: instruction present on InstrD before edge N appears on E outputs after edge N (1 cycle).
- Decoded opcodes:
  - lw 0000011: RegWrite=1, ResultSrc=01, ALUSrc=1, ImmSrc I, add.
  - sw 0100011: MemWrite=1, ALUSrc=1, ImmSrc S, add.
  - R-type 0110011: RegWrite=1. funct3 000 gives add, or sub when funct7[5]=1. funct3 111 and, 110 or, 010 slt.
  - I-ALU 0010011: as R-type with ALUSrc=1 and ImmSrc I. funct3 000 is always add.
  - beq 1100011: Branch=1, sub, ImmSrc B.
  - jal 1101111: RegWrite=1, Jump=1, ResultSrc=10, ImmSrc J.
- Any other opcode or funct3: all control bits 0 (bubble); register and immediate fields still registered.
- Immediates, all sign-extended from bit 31:
  - I: Instr[31:20]
  - S: {Instr[31:25],Instr[11:7]}
  - B: {Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}
  - J: {Instr[31],Instr[19:12],Instr[20],Instr[30:21],0}
- Register file: 2 combinational read ports, 1 write port on rising clk.
  - Write is ignored when RdW=0. Reads of x0 return 0.
  - Same-cycle write/read of the same nonzero register returns ResultW (write-through bypass), so RD1E/RD2E capture new data.
- FlushE=1 at an edge: E register loads all zeros, i.e. a NOP bubble with all control 0 and all data 0.
  - Regfile writes in that cycle still occur.
  - FlushE and reset together: reset wins.
- No stall input; the E register loads every cycle.

Test Plan:
- Reset: assert reset mid-cycle with valid InstrD → all E outputs 0 immediately, without waiting for a clock edge; after release, reading x5 returns 0.
- addi x5,x0,7: InstrD=0x00700293, PCD=0x10, PCPlus4D=0x14 → next edge RegWriteE=1, ALUSrcE=1, ALUControlE=000, RdE=5, Rs1E=0, RD1E=0, ImmExtE=7, PCE=0x10, PCPlus4E=0x14.
- Bypass: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF in the same cycle as InstrD=0x00512423 (sw x5,8(x2)) → MemWriteE=1, RegWriteE=0, Rs2E=5, RD2E=0xDEADBEEF, ImmExtE=8. Repeating with RdW=0 leaves x0 reading 0.
- Branch/jump immediates:
  - 0xFE208EE3 (beq x1,x2,-4) → BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC.
  - 0x008000EF (jal x1,8) → JumpE=1, ResultSrcE=10, RdE=1, ImmExtE=8.
- FlushE: FlushE=1 with InstrD=0x00700293 → all E outputs 0 after the edge. The next cycle, with FlushE=0, decodes normally.
- Illegal opcode: InstrD=0x0000007F → all control outputs 0; RdE=0, PCE tracks PCD.

Source files
------------

// File: rtl/decode_if.sv
// Decode-stage bus: fetch-side instruction/PC inputs, the writeback write port,
// the flush control, and everything the D/E register presents to execute.
// The slave modport is the decode stage; the master modport is whoever drives it.
interface decode_if #(parameter int XLEN = 32);
   logic [31:0]     InstrD;
   logic [XLEN-1:0] PCD;
   logic [XLEN-1:0] PCPlus4D;
   logic            FlushE;
   logic            RegWriteW;
   logic [4:0]      RdW;
   logic [XLEN-1:0] ResultW;

   logic            RegWriteE;
   logic [1:0]      ResultSrcE;
   logic            MemWriteE;
   logic            JumpE;
   logic            BranchE;
   logic [2:0]      ALUControlE;
   logic            ALUSrcE;
   logic [XLEN-1:0] RD1E;
   logic [XLEN-1:0] RD2E;
   logic [4:0]      Rs1E;
   logic [4:0]      Rs2E;
   logic [4:0]      RdE;
   logic [XLEN-1:0] ImmExtE;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] PCPlus4E;

   modport master (
      output InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
      input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
      input  RD1E, RD2E, Rs1E, Rs2E, RdE, ImmExtE, PCE, PCPlus4E
   );

   modport slave (
      input  InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
      output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
      output RD1E, RD2E, Rs1E, Rs2E, RdE, ImmExtE, PCE, PCPlus4E
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, register file with write-through bypass,
// immediate sign extension, and the D/E pipeline register.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input logic     clk,
   input logic     reset,
   decode_if.slave bus
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} immSrc_t;

   logic [XLEN-1:0] r_regs [NREGS];

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [4:0]      w_rd;
   logic [XLEN-1:0] w_rd1;
   logic [XLEN-1:0] w_rd2;
   logic [XLEN-1:0] w_immExt;
   immSrc_t         w_immSrc;
   logic [2:0]      w_aluFn;
   logic            w_aluLegal;
   logic            w_regWrite;
   logic [1:0]      w_resultSrc;
   logic            w_memWrite;
   logic            w_jump;
   logic            w_branch;
   logic [2:0]      w_aluControl;
   logic            w_aluSrc;

   logic            r_regWrite;
   logic [1:0]      r_resultSrc;
   logic            r_memWrite;
   logic            r_jump;
   logic            r_branch;
   logic [2:0]      r_aluControl;
   logic            r_aluSrc;
   logic [XLEN-1:0] r_rd1;
   logic [XLEN-1:0] r_rd2;
   logic [4:0]      r_rs1;
   logic [4:0]      r_rs2;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_immExt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_pcPlus4;

   assign w_opcode = bus.InstrD[6:0];
   assign w_funct3 = bus.InstrD[14:12];
   assign w_rs1    = bus.InstrD[19:15];
   assign w_rs2    = bus.InstrD[24:20];
   assign w_rd     = bus.InstrD[11:7];

   // Register file write port; x0 is never written so it always reads back zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (bus.RegWriteW && bus.RdW != 5'd0) begin
         r_regs[bus.RdW] <= bus.ResultW;
      end
   end

   // Read ports: x0 forced to zero, and a same-cycle writeback to the register
   // being read is forwarded so the E register captures the new value.
   always_comb begin
      w_rd1 = '0;
      w_rd2 = '0;
      if (w_rs1 != 5'd0)
         w_rd1 = (bus.RegWriteW && bus.RdW == w_rs1) ? bus.ResultW : r_regs[w_rs1];
      if (w_rs2 != 5'd0)
         w_rd2 = (bus.RegWriteW && bus.RdW == w_rs2) ? bus.ResultW : r_regs[w_rs2];
   end

   // ALU function from funct3, shared by R-type and I-ALU; sub only exists for R-type.
   always_comb begin
      w_aluLegal = 1'b1;
      w_aluFn    = ALU_ADD;
      case (w_funct3)
         3'b000:  w_aluFn = (w_opcode == OP_R && bus.InstrD[30]) ? ALU_SUB : ALU_ADD;
         3'b111:  w_aluFn = ALU_AND;
         3'b110:  w_aluFn = ALU_OR;
         3'b010:  w_aluFn = ALU_SLT;
         default: w_aluLegal = 1'b0;
      endcase
   end

   // Main control decode; the immediate format follows the opcode even when the
   // funct3 is unsupported and the control bits collapse to a bubble.
   always_comb begin
      w_regWrite   = 1'b0;
      w_resultSrc  = 2'b00;
      w_memWrite   = 1'b0;
      w_jump       = 1'b0;
      w_branch     = 1'b0;
      w_aluControl = ALU_ADD;
      w_aluSrc     = 1'b0;
      w_immSrc     = IMM_I;
      case (w_opcode)
         OP_LW: begin
            if (w_funct3 == 3'b010) begin
               w_regWrite  = 1'b1;
               w_resultSrc = 2'b01;
               w_aluSrc    = 1'b1;
            end
         end
         OP_SW: begin
            w_immSrc = IMM_S;
            if (w_funct3 == 3'b010) begin
               w_memWrite = 1'b1;
               w_aluSrc   = 1'b1;
            end
         end
         OP_R, OP_IALU: begin
            if (w_aluLegal) begin
               w_regWrite   = 1'b1;
               w_aluControl = w_aluFn;
               w_aluSrc     = (w_opcode == OP_IALU);
            end
         end
         OP_BEQ: begin
            w_immSrc = IMM_B;
            if (w_funct3 == 3'b000) begin
               w_branch     = 1'b1;
               w_aluControl = ALU_SUB;
            end
         end
         OP_JAL: begin
            w_immSrc    = IMM_J;
            w_regWrite  = 1'b1;
            w_jump      = 1'b1;
            w_resultSrc = 2'b10;
         end
         default: ;
      endcase
   end

   // Immediate sign extension from bit 31 for each format.
   always_comb begin
      w_immExt = '0;
      case (w_immSrc)
         IMM_I:   w_immExt = {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[31:20]};
         IMM_S:   w_immExt = {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
         IMM_B:   w_immExt = {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[7], bus.InstrD[30:25],
                              bus.InstrD[11:8], 1'b0};
         IMM_J:   w_immExt = {{(XLEN-20){bus.InstrD[31]}}, bus.InstrD[19:12], bus.InstrD[20],
                              bus.InstrD[30:21], 1'b0};
         default: w_immExt = '0;
      endcase
   end

   // D/E pipeline register: loads every cycle, flush turns it into an all-zero bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset || bus.FlushE) begin
         r_regWrite   <= 1'b0;
         r_resultSrc  <= 2'b00;
         r_memWrite   <= 1'b0;
         r_jump       <= 1'b0;
         r_branch     <= 1'b0;
         r_aluControl <= 3'b000;
         r_aluSrc     <= 1'b0;
         r_rd1        <= '0;
         r_rd2        <= '0;
         r_rs1        <= '0;
         r_rs2        <= '0;
         r_rd         <= '0;
         r_immExt     <= '0;
         r_pc         <= '0;
         r_pcPlus4    <= '0;
      end else begin
         r_regWrite   <= w_regWrite;
         r_resultSrc  <= w_resultSrc;
         r_memWrite   <= w_memWrite;
         r_jump       <= w_jump;
         r_branch     <= w_branch;
         r_aluControl <= w_aluControl;
         r_aluSrc     <= w_aluSrc;
         r_rd1        <= w_rd1;
         r_rd2        <= w_rd2;
         r_rs1        <= w_rs1;
         r_rs2        <= w_rs2;
         r_rd         <= w_rd;
         r_immExt     <= w_immExt;
         r_pc         <= bus.PCD;
         r_pcPlus4    <= bus.PCPlus4D;
      end
   end

   assign bus.RegWriteE   = r_regWrite;
   assign bus.ResultSrcE  = r_resultSrc;
   assign bus.MemWriteE   = r_memWrite;
   assign bus.JumpE       = r_jump;
   assign bus.BranchE     = r_branch;
   assign bus.ALUControlE = r_aluControl;
   assign bus.ALUSrcE     = r_aluSrc;
   assign bus.RD1E        = r_rd1;
   assign bus.RD2E        = r_rd2;
   assign bus.Rs1E        = r_rs1;
   assign bus.Rs2E        = r_rs2;
   assign bus.RdE         = r_rd;
   assign bus.ImmExtE     = r_immExt;
   assign bus.PCE         = r_pc;
   assign bus.PCPlus4E    = r_pcPlus4;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed vectors with literal expectations plus a
// behavioural reference model compared against the E register every cycle.
module tb_decode_stage;

   typedef struct packed {
      logic        regWrite;
      logic [1:0]  resultSrc;
      logic        memWrite;
      logic        jump;
      logic        branch;
      logic [2:0]  aluControl;
      logic        aluSrc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pc4;
   } eOut_t;

   logic        clk;
   logic        reset;
   int          checks;
   int          errors;
   logic        modelValid;
   logic [31:0] mRegs [32];
   eOut_t       expE;
   eOut_t       dutE;

   decode_if #(.XLEN(32)) bus ();

   decode_stage #(.XLEN(32), .NREGS(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign dutE = {bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.JumpE, bus.BranchE,
                  bus.ALUControlE, bus.ALUSrcE, bus.RD1E, bus.RD2E, bus.Rs1E, bus.Rs2E,
                  bus.RdE, bus.ImmExtE, bus.PCE, bus.PCPlus4E};

   // Architectural register read as seen by the instruction in decode this cycle.
   function automatic logic [31:0] readReg(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (bus.RegWriteW && bus.RdW == idx) return bus.ResultW;
      return mRegs[idx];
   endfunction

   // Reference decode straight from the instruction-set rules.
   function automatic eOut_t modelDecode(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] pc4);
      eOut_t      e;
      logic [6:0] op;
      logic [2:0] f3;
      int         aluFn;
      e     = '0;
      op    = ins[6:0];
      f3    = ins[14:12];
      e.rs1 = ins[19:15];
      e.rs2 = ins[24:20];
      e.rd  = ins[11:7];
      e.rd1 = readReg(ins[19:15]);
      e.rd2 = readReg(ins[24:20]);
      e.pc  = pc;
      e.pc4 = pc4;
      e.imm = 32'($signed(ins[31:20]));
      if (op == 7'b0100011) e.imm = 32'($signed({ins[31:25], ins[11:7]}));
      if (op == 7'b1100011) e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      if (op == 7'b1101111) e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      aluFn = -1;
      if (f3 == 3'b000) aluFn = (op == 7'b0110011 && ins[30]) ? 1 : 0;
      if (f3 == 3'b111) aluFn = 2;
      if (f3 == 3'b110) aluFn = 3;
      if (f3 == 3'b010) aluFn = 5;
      if (op == 7'b0000011 && f3 == 3'b010) begin
         e.regWrite = 1'b1; e.resultSrc = 2'd1; e.aluSrc = 1'b1;
      end else if (op == 7'b0100011 && f3 == 3'b010) begin
         e.memWrite = 1'b1; e.aluSrc = 1'b1;
      end else if ((op == 7'b0110011 || op == 7'b0010011) && aluFn >= 0) begin
         e.regWrite = 1'b1; e.aluControl = 3'(aluFn); e.aluSrc = (op == 7'b0010011);
      end else if (op == 7'b1100011 && f3 == 3'b000) begin
         e.branch = 1'b1; e.aluControl = 3'd1;
      end else if (op == 7'b1101111) begin
         e.regWrite = 1'b1; e.jump = 1'b1; e.resultSrc = 2'd2;
      end
      return e;
   endfunction

   // Reference model of the stage: E register contents and architectural registers.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         expE <= '0;
         for (int i = 0; i < 32; i++) mRegs[i] <= 32'd0;
      end else begin
         if (bus.FlushE) expE <= '0;
         else            expE <= modelDecode(bus.InstrD, bus.PCD, bus.PCPlus4D);
         if (bus.RegWriteW && bus.RdW != 5'd0) mRegs[bus.RdW] <= bus.ResultW;
      end
   end

   // Compare the whole E register against the model on every falling edge.
   always @(negedge clk) begin
      if (modelValid) begin
         checks++;
         if (dutE !== expE) begin
            errors++;
            $display("[TB] FAIL eRegister at %0t: actual=%h expected=%h", $time, dutE, expE);
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                input logic flush, input logic wen,
                                input logic [4:0] rdw, input logic [31:0] res);
      bus.InstrD    = instr;
      bus.PCD       = pc;
      bus.PCPlus4D  = pc + 32'd4;
      bus.FlushE    = flush;
      bus.RegWriteW = wen;
      bus.RdW       = rdw;
      bus.ResultW   = res;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   logic [6:0]  opList [8];
   logic [31:0] rnd;
   logic [31:0] rnd2;

   initial begin
      checks     = 0;
      errors     = 0;
      modelValid = 1'b0;
      reset      = 1'b0;
      bus.InstrD = 32'd0; bus.PCD = 32'd0; bus.PCPlus4D = 32'd0; bus.FlushE = 1'b0;
      bus.RegWriteW = 1'b0; bus.RdW = 5'd0; bus.ResultW = 32'd0;
      #2 reset = 1'b1;
      #1 modelValid = 1'b1;
      #19 reset = 1'b0;

      // Load x5 via writeback, then reset mid-cycle with a valid instruction in decode.
      applyStimulus(32'h00700293, 32'h0, 1'b0, 1'b1, 5'd5, 32'h00001234);
      bus.InstrD = 32'h00700293;
      #3 reset = 1'b1;
      #1;
      checkOutput("resetRegWriteE", 32'(bus.RegWriteE), 32'd0);
      checkOutput("resetImmExtE", bus.ImmExtE, 32'd0);
      checkOutput("resetRdE", 32'(bus.RdE), 32'd0);
      #4 reset = 1'b0;
      applyStimulus(32'h00028313, 32'h4, 1'b0, 1'b0, 5'd0, 32'd0);
      checkOutput("resetX5Cleared", bus.RD1E, 32'd0);

      // addi x5,x0,7
      applyStimulus(32'h00700293, 32'h10, 1'b0, 1'b0, 5'd0, 32'd0);
      checkOutput("addiRegWriteE", 32'(bus.RegWriteE), 32'd1);
      checkOutput("addiALUSrcE", 32'(bus.ALUSrcE), 32'd1);
      checkOutput("addiALUControlE", 32'(bus.ALUControlE), 32'd0);
      checkOutput("addiRdE", 32'(bus.RdE), 32'd5);
      checkOutput("addiRs1E", 32'(bus.Rs1E), 32'd0);
      checkOutput("addiRD1E", bus.RD1E, 32'd0);
      checkOutput("addiImmExtE", bus.ImmExtE, 32'd7);
      checkOutput("addiPCE", bus.PCE, 32'h10);
      checkOutput("addiPCPlus4E", bus.PCPlus4E, 32'h14);

      // sw x5,8(x2) with a same-cycle writeback to x5
      applyStimulus(32'h00512423, 32'h14, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
      checkOutput("bypassMemWriteE", 32'(bus.MemWriteE), 32'd1);
      checkOutput("bypassRegWriteE", 32'(bus.RegWriteE), 32'd0);
      checkOutput("bypassRs2E", 32'(bus.Rs2E), 32'd5);
      checkOutput("bypassRD2E", bus.RD2E, 32'hDEADBEEF);
      checkOutput("bypassImmExtE", bus.ImmExtE, 32'd8);
      applyStimulus(32'h00012423, 32'h18, 1'b0, 1'b1, 5'd0, 32'hCAFEF00D);
      checkOutput("x0WriteIgnored", bus.RD2E, 32'd0);
      applyStimulus(32'h00512423, 32'h1C, 1'b0, 1'b0, 5'd0, 32'd0);
      checkOutput("x5Stored", bus.RD2E, 32'hDEADBEEF);

      // beq x1,x2,-4 and jal x1,8
      applyStimulus(32'hFE208EE3, 32'h20, 1'b0, 1'b0, 5'd0, 32'd0);
      checkOutput("beqBranchE", 32'(bus.BranchE), 32'd1);
      checkOutput("beqALUControlE", 32'(bus.ALUControlE), 32'd1);
      checkOutput("beqImmExtE", bus.ImmExtE, 32'hFFFFFFFC);
      applyStimulus(32'h008000EF, 32'h24, 1'b0, 1'b0, 5'd0, 32'd0);
      checkOutput("jalJumpE", 32'(bus.JumpE), 32'd1);
      checkOutput("jalResultSrcE", 32'(bus.ResultSrcE), 32'd2);
      checkOutput("jalRdE", 32'(bus.RdE), 32'd1);
      checkOutput("jalImmExtE", bus.ImmExtE, 32'd8);

      // Flush with a write to x7 in the same cycle, then addi x8,x7,1
      applyStimulus(32'h00700293, 32'h28, 1'b1, 1'b1, 5'd7, 32'h00000055);
      checkOutput("flushRegWriteE", 32'(bus.RegWriteE), 32'd0);
      checkOutput("flushImmExtE", bus.ImmExtE, 32'd0);
      checkOutput("flushPCE", bus.PCE, 32'd0);
      applyStimulus(32'h00138413, 32'h2C, 1'b0, 1'b0, 5'd0, 32'd0);
      checkOutput("afterFlushRegWriteE", 32'(bus.RegWriteE), 32'd1);
      checkOutput("afterFlushRD1E", bus.RD1E, 32'h55);
      checkOutput("afterFlushImmExtE", bus.ImmExtE, 32'd1);

      // Illegal opcode
      applyStimulus(32'h0000007F, 32'h40, 1'b0, 1'b0, 5'd0, 32'd0);
      checkOutput("illegalRegWriteE", 32'(bus.RegWriteE), 32'd0);
      checkOutput("illegalMemWriteE", 32'(bus.MemWriteE), 32'd0);
      checkOutput("illegalRdE", 32'(bus.RdE), 32'd0);
      checkOutput("illegalPCE", bus.PCE, 32'h40);

      // R-type variants and an unsupported funct3
      applyStimulus(rType(7'h20, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h44, 1'b0, 1'b0, 5'd0, 32'd0);
      checkOutput("subALUControlE", 32'(bus.ALUControlE), 32'd1);
      applyStimulus(rType(7'h00, 5'd2, 5'd1, 3'b010, 5'd3, 7'b0110011), 32'h48, 1'b0, 1'b0, 5'd0, 32'd0);
      checkOutput("sltALUControlE", 32'(bus.ALUControlE), 32'd5);
      applyStimulus(rType(7'h20, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0010011), 32'h4C, 1'b0, 1'b0, 5'd0, 32'd0);
      checkOutput("addiHighImmIsAdd", 32'(bus.ALUControlE), 32'd0);
      applyStimulus(rType(7'h00, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011), 32'h50, 1'b0, 1'b0, 5'd0, 32'd0);
      checkOutput("badFunct3RegWriteE", 32'(bus.RegWriteE), 32'd0);

      // Mixed instructions with random fields and writebacks, checked by the model.
      opList = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                 7'b1100011, 7'b1101111, 7'b0110111, 7'b1111111};
      for (int k = 0; k < 40; k++) begin
         rnd  = $urandom();
         rnd2 = $urandom();
         applyStimulus({rnd[31:7], opList[rnd2[2:0]]}, 32'h100 + 32'(k * 4),
                       (rnd2[7:4] == 4'd0), rnd2[8], rnd2[13:9], $urandom());
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
